// File: rtl/axis_insert_pkg.sv
// Shared types, constants and helpers for the AXI4-Stream packet inserter.
package axis_insert_pkg;

  typedef enum logic [1:0] {
    PASS_IDLE = 2'd0,
    PASS_PKT  = 2'd1,
    INSERT    = 2'd2
  } insert_state_t;

  localparam int unsigned MIN_LEN        = 60;
  localparam int unsigned MAX_LEN        = 1518;
  localparam int unsigned BYTES_PER_BEAT = 32;
  localparam int unsigned TUSER_LEN_LSB  = 0;
  localparam int unsigned TUSER_DST_LSB  = 24;

  // Clamped lengths never exceed 1518, so 11 bits hold them.
  localparam int unsigned LEN_W  = 11;
  // At most 48 beats per packet.
  localparam int unsigned BEAT_W = 6;

  // Force a requested byte length into the legal Ethernet frame range.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] len);
    if (len < 16'(MIN_LEN)) begin
      return LEN_W'(MIN_LEN);
    end else if (len > 16'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end else begin
      return len[LEN_W-1:0];
    end
  endfunction

  // Number of 32-byte beats needed to carry a clamped length (ceiling divide).
  function automatic logic [BEAT_W-1:0] beats_for_len(input logic [LEN_W-1:0] len);
    return BEAT_W'(({1'b0, len} + (LEN_W+1)'(BYTES_PER_BEAT - 1)) >> $clog2(BYTES_PER_BEAT));
  endfunction

endpackage

// File: rtl/axis_insert_beat_gen.sv
// Generates the beats of one inserted packet: beat counter, lane data, tkeep and tuser.
module axis_insert_beat_gen
  import axis_insert_pkg::*;
#(
  parameter int DW = 256,
  parameter int UW = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            advance_i,
  input  logic [15:0]     cfg_len_i,
  input  logic [31:0]     cfg_pattern_i,
  input  logic [7:0]      cfg_dst_port_i,
  output logic [DW-1:0]   tdata_o,
  output logic [DW/8-1:0] tkeep_o,
  output logic [UW-1:0]   tuser_o,
  output logic            tlast_o
);

  localparam int LANES = DW / 32;
  localparam int KW    = DW / 8;

  logic [LEN_W-1:0]  len_q;
  logic [31:0]       pattern_q;
  logic [7:0]        dst_q;
  logic [BEAT_W-1:0] beatCnt_q;
  logic [BEAT_W-1:0] beatCnt_d;
  logic [BEAT_W-1:0] numBeats;

  assign numBeats = beats_for_len(len_q);
  assign tlast_o  = (beatCnt_q == (numBeats - BEAT_W'(1)));

  // Next beat index: restart on load, step on each accepted beat, wrap after the last one.
  always_comb begin
    beatCnt_d = beatCnt_q;
    if (load_i) begin
      beatCnt_d = '0;
    end else if (advance_i) begin
      beatCnt_d = tlast_o ? '0 : beatCnt_q + BEAT_W'(1);
    end
  end

  // Snapshot the configuration when a packet starts so mid-packet register writes are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= LEN_W'(MIN_LEN);
      pattern_q <= '0;
      dst_q     <= '0;
      beatCnt_q <= '0;
    end else begin
      beatCnt_q <= beatCnt_d;
      if (load_i) begin
        len_q     <= clamp_len(cfg_len_i);
        pattern_q <= cfg_pattern_i;
        dst_q     <= cfg_dst_port_i;
      end
    end
  end

  // Lane k of beat b carries pattern + 8*b + k; everything is derived from registers so it holds under stall.
  always_comb begin
    tdata_o = '0;
    for (int k = 0; k < LANES; k++) begin
      tdata_o[32*k +: 32] = pattern_q + (32'(beatCnt_q) << 3) + 32'(k);
    end
  end

  // Only the final beat may be partial; a zero remainder means it is full.
  always_comb begin
    tkeep_o = '1;
    if (tlast_o && (len_q[4:0] != 5'd0)) begin
      tkeep_o = (KW'(1) << len_q[4:0]) - KW'(1);
    end
  end

  // Metadata: byte length in the low half-word and the one-hot destination port.
  always_comb begin
    tuser_o = '0;
    tuser_o[TUSER_LEN_LSB +: 16] = 16'(len_q);
    tuser_o[TUSER_DST_LSB +: 8]  = dst_q;
  end

endmodule

// File: rtl/axis_packet_inserter.sv
// Merges locally generated test packets into a passthrough AXI4-Stream at packet boundaries.
module axis_packet_inserter
  import axis_insert_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            cfg_enable,
  input  logic                            cfg_start,
  input  logic [15:0]                     cfg_len,
  input  logic [31:0]                     cfg_pattern,
  input  logic [7:0]                      cfg_dst_port,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [31:0]                     stat_insert_cnt,
  output logic                            stat_busy
);

  insert_state_t state_q, state_d;
  logic          pending_q, pending_d;
  logic [31:0]   insertCnt_q, insertCnt_d;

  logic [C_AXIS_DATA_WIDTH-1:0]   genData;
  logic [C_AXIS_DATA_WIDTH/8-1:0] genKeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  genUser;
  logic                           genLast;

  logic genLoad;
  logic insertAccept;
  logic insertDone;
  logic passAccept;

  assign genLoad      = (state_q == PASS_IDLE) && pending_q;
  assign insertAccept = (state_q == INSERT) && m_axis_tready;
  assign insertDone   = insertAccept && genLast;
  assign passAccept   = s_axis_tvalid && s_axis_tready && (state_q != INSERT);

  axis_insert_beat_gen #(
    .DW (C_AXIS_DATA_WIDTH),
    .UW (C_AXIS_TUSER_WIDTH)
  ) u_beat_gen (
    .clk            (ACLK),
    .rst_n          (ARESETN),
    .load_i         (genLoad),
    .advance_i      (insertAccept),
    .cfg_len_i      (cfg_len),
    .cfg_pattern_i  (cfg_pattern),
    .cfg_dst_port_i (cfg_dst_port),
    .tdata_o        (genData),
    .tkeep_o        (genKeep),
    .tuser_o        (genUser),
    .tlast_o        (genLast)
  );

  // Output mux: wire straight through in passthrough, hold upstream off while a request or insert owns the bus.
  always_comb begin
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tuser  = s_axis_tuser;
    m_axis_tlast  = s_axis_tlast;
    m_axis_tvalid = s_axis_tvalid && ARESETN;
    s_axis_tready = m_axis_tready && ARESETN;
    case (state_q)
      PASS_IDLE: begin
        if (pending_q) begin
          m_axis_tvalid = 1'b0;
          s_axis_tready = 1'b0;
        end
      end
      INSERT: begin
        m_axis_tdata  = genData;
        m_axis_tkeep  = genKeep;
        m_axis_tuser  = genUser;
        m_axis_tlast  = genLast;
        m_axis_tvalid = 1'b1;
        s_axis_tready = 1'b0;
      end
      default: ;
    endcase
  end

  // Next-state logic: only switch sources between passthrough packets.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS_IDLE: begin
        if (pending_q) begin
          state_d = INSERT;
        end else if (passAccept && !s_axis_tlast) begin
          state_d = PASS_PKT;
        end
      end
      PASS_PKT: begin
        if (passAccept && s_axis_tlast) begin
          state_d = PASS_IDLE;
        end
      end
      INSERT: begin
        if (insertDone) begin
          state_d = PASS_IDLE;
        end
      end
      default: state_d = PASS_IDLE;
    endcase
  end

  // Request latch and completion counter; disable cancels a waiting request but never an active insert.
  always_comb begin
    pending_d   = pending_q;
    insertCnt_d = insertCnt_q;
    if (!cfg_enable) begin
      pending_d = 1'b0;
    end else if (cfg_start && (state_q != INSERT)) begin
      pending_d = 1'b1;
    end
    if (insertDone) begin
      pending_d   = 1'b0;
      insertCnt_d = insertCnt_q + 32'd1;
    end
  end

  // State registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= PASS_IDLE;
      pending_q   <= 1'b0;
      insertCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      insertCnt_q <= insertCnt_d;
    end
  end

  assign stat_insert_cnt = insertCnt_q;
  assign stat_busy       = pending_q || (state_q == INSERT);

endmodule

// File: tb/tb_axis_packet_inserter.sv
// Directed scoreboard bench for the AXI4-Stream packet inserter.
module tb_axis_packet_inserter;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         ACLK;
  logic         ARESETN;
  logic         cfg_enable;
  logic         cfg_start;
  logic [15:0]  cfg_len;
  logic [31:0]  cfg_pattern;
  logic [7:0]   cfg_dst_port;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [31:0]  stat_insert_cnt;
  logic         stat_busy;

  int    testCount = 0;
  int    failCount = 0;
  int    expCnt    = 0;
  beat_t expQ[$];
  beat_t capQ[$];

  beat_t monCur;
  beat_t monExp;
  beat_t holdBeat;
  logic  holdValid = 1'b0;
  beat_t tmp;

  axis_packet_inserter dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .cfg_enable      (cfg_enable),
    .cfg_start       (cfg_start),
    .cfg_len         (cfg_len),
    .cfg_pattern     (cfg_pattern),
    .cfg_dst_port    (cfg_dst_port),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .stat_insert_cnt (stat_insert_cnt),
    .stat_busy       (stat_busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model of one inserted packet, pushed in output order.
  function automatic void pushInsert(input logic [15:0] len, input logic [31:0] pat, input logic [7:0] dst);
    int    lenC;
    int    n;
    beat_t bt;
    lenC = int'(len);
    if (lenC < 60)   lenC = 60;
    if (lenC > 1518) lenC = 1518;
    n = (lenC + 31) / 32;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 8; k++) bt.data[32*k +: 32] = pat + 32'(8*b + k);
      bt.last = (b == n - 1);
      if (bt.last && ((lenC % 32) != 0)) bt.keep = (32'h1 << (lenC % 32)) - 32'h1;
      else bt.keep = '1;
      bt.user = '0;
      bt.user[15:0]  = 16'(lenC);
      bt.user[31:24] = dst;
      expQ.push_back(bt);
    end
  endfunction

  // Output monitor: scoreboard pop on every handshake and stability check on every stall.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      holdValid = 1'b0;
    end else begin
      monCur = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser, last: m_axis_tlast};
      if (holdValid) begin
        checkOutput("hold_valid", 256'(m_axis_tvalid), 256'd1);
        checkOutput("hold_data", monCur.data, holdBeat.data);
        checkOutput("hold_side", 256'({monCur.keep, monCur.user, monCur.last}),
                    256'({holdBeat.keep, holdBeat.user, holdBeat.last}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checkOutput("beat_expected", 256'(expQ.size() != 0), 256'd1);
        if (expQ.size() != 0) begin
          monExp = expQ.pop_front();
          checkOutput("beat_data", monCur.data, monExp.data);
          checkOutput("beat_keep", 256'(monCur.keep), 256'(monExp.keep));
          checkOutput("beat_user", 256'(monCur.user), 256'(monExp.user));
          checkOutput("beat_last", 256'(monCur.last), 256'(monExp.last));
        end
        capQ.push_back(monCur);
      end
      holdValid = m_axis_tvalid && !m_axis_tready;
      holdBeat  = monCur;
    end
  end

  // Send an n-beat passthrough packet, expecting it unchanged at the output with zero latency.
  task automatic applyStimulus(input int n);
    beat_t pkt[$];
    beat_t bt;
    logic  acc;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 8; k++) bt.data[32*k +: 32] = $urandom();
      bt.user = {$urandom(), $urandom(), $urandom(), $urandom()};
      bt.last = (b == n - 1);
      bt.keep = bt.last ? 32'h0000FFFF : 32'hFFFFFFFF;
      pkt.push_back(bt);
      expQ.push_back(bt);
    end
    foreach (pkt[i]) begin
      s_axis_tdata  = pkt[i].data;
      s_axis_tkeep  = pkt[i].keep;
      s_axis_tuser  = pkt[i].user;
      s_axis_tlast  = pkt[i].last;
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge ACLK);
        if (s_axis_tready) acc = 1'b1;
        else begin
          @(posedge ACLK); #1;
        end
      end
      checkOutput("upstream_accept", 256'(acc), 256'd1);
      if (acc) begin
        checkOutput("pass_zero_latency", 256'(m_axis_tvalid), 256'd1);
        checkOutput("pass_data_now", m_axis_tdata, pkt[i].data);
      end
      @(posedge ACLK); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pulseStart(input bit expectPacket);
    @(posedge ACLK); #1;
    cfg_start = 1'b1;
    if (expectPacket) pushInsert(cfg_len, cfg_pattern, cfg_dst_port);
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has appeared and the block is idle.
  task automatic waitDrain(input bit randomReady, input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(posedge ACLK); #1;
      if (randomReady) m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge ACLK); #1;
      if (expQ.size() == 0 && !stat_busy) done = 1'b1;
    end
    m_axis_tready = 1'b1;
    checkOutput("drain_in_time", 256'(done), 256'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESETN = 1'b0; cfg_enable = 1'b0; cfg_start = 1'b0; cfg_len = '0;
    cfg_pattern = '0; cfg_dst_port = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    #12;
    checkOutput("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    checkOutput("rst_s_tready", 256'(s_axis_tready), 256'd0);
    checkOutput("rst_cnt", 256'(stat_insert_cnt), 256'd0);
    checkOutput("rst_busy", 256'(stat_busy), 256'd0);
    s_axis_tvalid = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Idle passthrough
    applyStimulus(3);
    waitDrain(1'b0, 50);
    checkOutput("pass_cnt", 256'(stat_insert_cnt), 256'd0);

    // Single insert with latency check
    cfg_enable = 1'b1; cfg_len = 16'd100; cfg_pattern = 32'h1000; cfg_dst_port = 8'h04;
    capQ.delete();
    pulseStart(1'b1);
    @(negedge ACLK);
    checkOutput("ins_pending_gap_valid", 256'(m_axis_tvalid), 256'd0);
    checkOutput("ins_busy", 256'(stat_busy), 256'd1);
    @(negedge ACLK);
    checkOutput("ins_first_valid", 256'(m_axis_tvalid), 256'd1);
    waitDrain(1'b0, 100);
    expCnt++;
    checkOutput("ins_beats", 256'(capQ.size()), 256'd4);
    tmp = capQ[0];
    checkOutput("ins_b0_l0", 256'(tmp.data[31:0]), 256'h1000);
    tmp = capQ[3];
    checkOutput("ins_b3_l7", 256'(tmp.data[255:224]), 256'h101F);
    checkOutput("ins_last_keep", 256'(tmp.keep), 256'h0000000F);
    checkOutput("ins_user_len", 256'(tmp.user[15:0]), 256'd100);
    checkOutput("ins_user_dst", 256'(tmp.user[31:24]), 256'h04);
    checkOutput("ins_cnt", 256'(stat_insert_cnt), 256'(expCnt));
    checkOutput("ins_busy_end", 256'(stat_busy), 256'd0);

    // Boundary respect: start during beat 1 of a 5-beat packet
    cfg_pattern = 32'h2000;
    capQ.delete();
    fork
      applyStimulus(5);
      pulseStart(1'b1);
    join
    waitDrain(1'b0, 100);
    expCnt++;
    checkOutput("bnd_beats", 256'(capQ.size()), 256'd9);
    tmp = capQ[4];
    checkOutput("bnd_pass_last", 256'(tmp.last), 256'd1);
    tmp = capQ[5];
    checkOutput("bnd_ins_first", 256'(tmp.data[31:0]), 256'h2000);
    checkOutput("bnd_cnt", 256'(stat_insert_cnt), 256'(expCnt));

    // Short length clamps up to 60
    cfg_len = 16'd10; cfg_pattern = 32'h0; cfg_dst_port = 8'h01;
    capQ.delete();
    pulseStart(1'b1);
    waitDrain(1'b0, 100);
    expCnt++;
    checkOutput("min_beats", 256'(capQ.size()), 256'd2);
    tmp = capQ[1];
    checkOutput("min_keep", 256'(tmp.keep), 256'h0FFFFFFF);
    checkOutput("min_user", 256'(tmp.user[15:0]), 256'd60);

    // Long length clamps to 1518, under random backpressure
    cfg_len = 16'd2000; cfg_pattern = 32'hABCD0000; cfg_dst_port = 8'h80;
    capQ.delete();
    pulseStart(1'b1);
    waitDrain(1'b1, 2000);
    expCnt++;
    checkOutput("max_beats", 256'(capQ.size()), 256'd48);
    tmp = capQ[47];
    checkOutput("max_user", 256'(tmp.user[15:0]), 256'd1518);
    checkOutput("max_cnt", 256'(stat_insert_cnt), 256'(expCnt));

    // Lane arithmetic wraps modulo 2^32
    cfg_len = 16'd64; cfg_pattern = 32'hFFFFFFFC;
    capQ.delete();
    pulseStart(1'b1);
    waitDrain(1'b0, 100);
    expCnt++;
    tmp = capQ[0];
    checkOutput("wrap_lane4", 256'(tmp.data[159:128]), 256'h0);

    // Second start during INSERT is ignored
    cfg_len = 16'd200; cfg_pattern = 32'h5000;
    capQ.delete();
    pulseStart(1'b1);
    repeat (3) @(posedge ACLK);
    #1;
    pulseStart(1'b0);
    waitDrain(1'b0, 100);
    repeat (5) @(posedge ACLK);
    #1;
    expCnt++;
    checkOutput("dbl_beats", 256'(capQ.size()), 256'd7);
    checkOutput("dbl_cnt", 256'(stat_insert_cnt), 256'(expCnt));
    checkOutput("dbl_busy", 256'(stat_busy), 256'd0);

    // Enable dropped mid-insert still completes the packet
    cfg_len = 16'd300; cfg_pattern = 32'h7000;
    pulseStart(1'b1);
    repeat (2) @(posedge ACLK);
    #1;
    cfg_enable = 1'b0;
    waitDrain(1'b0, 100);
    expCnt++;
    checkOutput("dis_cnt", 256'(stat_insert_cnt), 256'(expCnt));
    pulseStart(1'b0);
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("dis_blocked_busy", 256'(stat_busy), 256'd0);
    checkOutput("dis_blocked_cnt", 256'(stat_insert_cnt), 256'(expCnt));
    cfg_enable = 1'b1;

    // Reset mid-insert aborts at once
    cfg_len = 16'd500; cfg_pattern = 32'h9000;
    pulseStart(1'b1);
    repeat (4) @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    expQ.delete();
    #2;
    checkOutput("abort_tvalid", 256'(m_axis_tvalid), 256'd0);
    checkOutput("abort_s_tready", 256'(s_axis_tready), 256'd0);
    checkOutput("abort_cnt", 256'(stat_insert_cnt), 256'd0);
    checkOutput("abort_busy", 256'(stat_busy), 256'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("post_abort_tvalid", 256'(m_axis_tvalid), 256'd0);
    checkOutput("post_abort_busy", 256'(stat_busy), 256'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
